free_list: RTL and testbench

Physical-register free list for the rename stage. It holds the physical tags not currently mapped or in flight. It hands up to two new tags per cycle to dispatch and the map table (`arch_reg_dest_new_tag_i`, `new_tag_write_en_i`). It takes back up to two old tags per cycle from the ROB at retirement. On a branch mispredict it restores itself in one cycle, in step with the map table's arch-table recovery.

---
 rtl/free_list_pkg.sv | 32 +++
 rtl/free_list_if.sv | 34 +++
 rtl/free_list_ptr_advance.sv | 36 +++
 rtl/free_list.sv | 139 +++++++++++++
 tb/tb_free_list.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module      : free_list_pkg
// Description : Shared rename-stage definitions: physical/architectural
//               register counts, tag type and destination-select encoding.
//               Used by the free list, map table, ROB and RS.
// Revision    : 1.0 - initial release
// ============================================================================
package free_list_pkg;

    localparam int PREG_NUMBER    = 64;
    localparam int ARCHREG_NUMBER = 32;
    localparam int TABLE_WRITE    = 2;

    localparam int DISPATCH_WIDTH = TABLE_WRITE;
    localparam int RETIRE_WIDTH   = 2;

    localparam int TAG_W = $clog2(PREG_NUMBER);
    localparam int DEPTH = PREG_NUMBER - ARCHREG_NUMBER;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [TAG_W-1:0] preg_tag_t;

    // Which instruction field names the destination register.
    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_reg_sel_t;

endpackage : free_list_pkg
`default_nettype wire

// File: rtl/free_list_if.sv
`default_nettype none
// ============================================================================
// Module      : free_list_if
// Description : Dispatch/retire bundle between the free list and its users.
//               slave  : the free list itself
//               master : dispatch + ROB side
// Signals     : alloc_i, free_en_i, free_tag_i, branch_recover_i (to list)
//               new_tag_o, new_tag_write_en_o, free_count_o, stall_o (from)
// Revision    : 1.0 - initial release
// ============================================================================
interface free_list_if;
    import free_list_pkg::*;

    logic [DISPATCH_WIDTH-1:0]            alloc_i;
    logic [RETIRE_WIDTH-1:0]              free_en_i;
    preg_tag_t [RETIRE_WIDTH-1:0]         free_tag_i;
    logic                                 branch_recover_i;
    preg_tag_t [DISPATCH_WIDTH-1:0]       new_tag_o;
    logic [DISPATCH_WIDTH-1:0]            new_tag_write_en_o;
    logic [CNT_W-1:0]                     free_count_o;
    logic                                 stall_o;

    modport master (
        output alloc_i, free_en_i, free_tag_i, branch_recover_i,
        input  new_tag_o, new_tag_write_en_o, free_count_o, stall_o
    );

    modport slave (
        input  alloc_i, free_en_i, free_tag_i, branch_recover_i,
        output new_tag_o, new_tag_write_en_o, free_count_o, stall_o
    );

endinterface : free_list_if
`default_nettype wire

// File: rtl/free_list_ptr_advance.sv
`default_nettype none
// ============================================================================
// Module      : ptr_advance
// Description : Modulo-MODULUS pointer add of a small increment. MODULUS need
//               not be a power of two, so the wrap is a compare-and-subtract.
//               Requires inc_i < MODULUS.
// Ports       : ptr_i  - current pointer (0..MODULUS-1)
//               inc_i  - increment
//               ptr_o  - (ptr_i + inc_i) mod MODULUS
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_advance #(
    parameter int MODULUS = 32,
    parameter int PTR_W   = 5,
    parameter int INC_W   = 2
) (
    input  wire logic [PTR_W-1:0] ptr_i,
    input  wire logic [INC_W-1:0] inc_i,
    output logic      [PTR_W-1:0] ptr_o
);

    logic [PTR_W:0] w_sum;
    logic [PTR_W:0] w_wrapped;

    always_comb begin
        w_sum     = {1'b0, ptr_i} + (PTR_W+1)'(inc_i);
        w_wrapped = w_sum;
        if (w_sum >= (PTR_W+1)'(MODULUS)) begin
            w_wrapped = w_sum - (PTR_W+1)'(MODULUS);
        end
    end

    assign ptr_o = w_wrapped[PTR_W-1:0];

endmodule : ptr_advance
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module      : free_list
// Description : Physical-register free list for rename. Circular buffer of
//               DEPTH tags with head (next alloc), tail (next free write) and
//               count. Up to DISPATCH_WIDTH grants and RETIRE_WIDTH frees per
//               cycle; single-cycle restore on branch mispredict.
// Ports       : clk, reset (sync, active high)
//               bus (free_list_if.slave): alloc/free requests in,
//               allocated tags, grants, free count and stall out
// Revision    : 1.0 - initial release
// ============================================================================
module free_list
    import free_list_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    free_list_if.slave      bus
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_max_w = (DISPATCH_WIDTH > RETIRE_WIDTH) ? DISPATCH_WIDTH : RETIRE_WIDTH;
    localparam int c_inc_w = $clog2(c_max_w + 1);

    preg_tag_t          r_buf [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [DISPATCH_WIDTH-1:0][c_inc_w-1:0] w_rd_off;
    logic [DISPATCH_WIDTH-1:0][c_ptr_w-1:0] w_rd_idx;
    logic [DISPATCH_WIDTH-1:0]              w_grant;
    logic [c_inc_w-1:0]                     w_n_grant;
    logic [RETIRE_WIDTH-1:0][c_inc_w-1:0]   w_wr_off;
    logic [RETIRE_WIDTH-1:0][c_ptr_w-1:0]   w_wr_idx;
    logic [c_inc_w-1:0]                     w_n_free;
    logic [c_ptr_w-1:0]                     w_head_next;
    logic [c_ptr_w-1:0]                     w_tail_next;
    logic [CNT_W-1:0]                       w_count_next;

    // Requests are packed: a requesting slot reads head + (requests below it).
    // An idle slot shows head + slot index so the tag bus still presents
    // consecutive buffer entries when nothing is requested.
    always_comb begin : alloc_rank
        logic [c_inc_w-1:0] rank;
        rank      = '0;
        w_n_grant = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            w_rd_off[i] = bus.alloc_i[i] ? rank : c_inc_w'(i);
            w_grant[i]  = bus.alloc_i[i] & (CNT_W'(rank) < r_count)
                        & ~bus.branch_recover_i & ~reset;
            if (w_grant[i]) begin
                w_n_grant = w_n_grant + c_inc_w'(1);
            end
            if (bus.alloc_i[i]) begin
                rank = rank + c_inc_w'(1);
            end
        end
    end

    always_comb begin : free_rank
        logic [c_inc_w-1:0] rank;
        rank = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            w_wr_off[i] = rank;
            if (bus.free_en_i[i]) begin
                rank = rank + c_inc_w'(1);
            end
        end
        w_n_free = rank;
    end

    generate
        for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_rd_idx
            ptr_advance #(.MODULUS(DEPTH), .PTR_W(c_ptr_w), .INC_W(c_inc_w)) u_rd (
                .ptr_i (r_head),
                .inc_i (w_rd_off[i]),
                .ptr_o (w_rd_idx[i])
            );
            assign bus.new_tag_o[i] = r_buf[w_rd_idx[i]];
        end

        for (genvar i = 0; i < RETIRE_WIDTH; i++) begin : g_wr_idx
            ptr_advance #(.MODULUS(DEPTH), .PTR_W(c_ptr_w), .INC_W(c_inc_w)) u_wr (
                .ptr_i (r_tail),
                .inc_i (w_wr_off[i]),
                .ptr_o (w_wr_idx[i])
            );
        end
    endgenerate

    ptr_advance #(.MODULUS(DEPTH), .PTR_W(c_ptr_w), .INC_W(c_inc_w)) u_head (
        .ptr_i (r_head),
        .inc_i (w_n_grant),
        .ptr_o (w_head_next)
    );

    ptr_advance #(.MODULUS(DEPTH), .PTR_W(c_ptr_w), .INC_W(c_inc_w)) u_tail (
        .ptr_i (r_tail),
        .inc_i (w_n_free),
        .ptr_o (w_tail_next)
    );

    assign w_count_next = r_count + CNT_W'(w_n_free) - CNT_W'(w_n_grant);

    assign bus.new_tag_write_en_o = w_grant;
    assign bus.free_count_o       = r_count;
    assign bus.stall_o            = (r_count < CNT_W'(DISPATCH_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_buf[k] <= TAG_W'(ARCHREG_NUMBER + k);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNT_W'(DEPTH);
        end else begin
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                if (bus.free_en_i[i]) begin
                    r_buf[w_wr_idx[i]] <= bus.free_tag_i[i];
                end
            end
            r_tail <= w_tail_next;
            if (bus.branch_recover_i) begin
                // Every in-flight tag returns at once: since count plus
                // in-flight always equals DEPTH, the whole ring (ending at
                // the new tail) is exactly the set of unmapped pregs.
                r_head  <= w_tail_next;
                r_count <= CNT_W'(DEPTH);
            end else begin
                r_head  <= w_head_next;
                r_count <= w_count_next;
            end
        end
    end

endmodule : free_list
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_list
// Description : Directed self-checking bench for free_list (PREG 64, ARCH 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list;
    import free_list_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    free_list_if bus ();

    free_list dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Input legality: x0 is never freed, and frees never overfill the ring.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                assert (!(bus.free_en_i[i] && bus.free_tag_i[i] == '0))
                    else $error("illegal free of preg 0 on slot %0d", i);
            end
            assert (int'(bus.free_count_o) + $countones(bus.free_en_i) <= DEPTH)
                else $error("free overflow: count %0d frees %0d",
                            bus.free_count_o, $countones(bus.free_en_i));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.alloc_i          = '0;
        bus.free_en_i        = '0;
        bus.free_tag_i       = '0;
        bus.branch_recover_i = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(32)) begin
            errors++; $display("FAIL reset_count: got %0d want 32", bus.free_count_o);
        end
        checks++;
        if (bus.new_tag_o[0] !== TAG_W'(32) || bus.new_tag_o[1] !== TAG_W'(33)) begin
            errors++; $display("FAIL reset_tags: got {%0d,%0d} want {33,32}", bus.new_tag_o[1], bus.new_tag_o[0]);
        end
        checks++;
        if (bus.stall_o !== 1'b0 || bus.new_tag_write_en_o !== 2'b00) begin
            errors++; $display("FAIL reset_stall_we: got stall=%b we=%b want 0/00", bus.stall_o, bus.new_tag_write_en_o);
        end
        tick();
    endtask

    // Drain all 32 tags two per cycle, then show the stall/no-grant state.
    task automatic test_drain();
        for (int c = 0; c < 16; c++) begin
            bus.alloc_i = 2'b11;
            @(negedge clk);
            checks++;
            if (bus.new_tag_write_en_o !== 2'b11 || bus.new_tag_o[0] !== TAG_W'(32 + 2*c)
                || bus.new_tag_o[1] !== TAG_W'(33 + 2*c)) begin
                errors++; $display("FAIL drain_c%0d: got we=%b {%0d,%0d} want 11 {%0d,%0d}", c,
                    bus.new_tag_write_en_o, bus.new_tag_o[1], bus.new_tag_o[0], 33 + 2*c, 32 + 2*c);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.new_tag_write_en_o !== 2'b00 || bus.stall_o !== 1'b1 || bus.free_count_o !== CNT_W'(0)) begin
            errors++; $display("FAIL drain_empty: got we=%b stall=%b count=%0d want 00/1/0",
                bus.new_tag_write_en_o, bus.stall_o, bus.free_count_o);
        end
        tick();
        drive_idle();
    endtask

    // Empty list: a same-cycle free cannot satisfy an alloc.
    task automatic test_no_bypass();
        bus.alloc_i       = 2'b11;
        bus.free_en_i     = 2'b11;
        bus.free_tag_i[0] = TAG_W'(5);
        bus.free_tag_i[1] = TAG_W'(7);
        @(negedge clk);
        checks++;
        if (bus.new_tag_write_en_o !== 2'b00) begin
            errors++; $display("FAIL bypass_grant: got we=%b want 00", bus.new_tag_write_en_o);
        end
        tick();
        bus.free_en_i = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(2) || bus.new_tag_write_en_o !== 2'b11
            || bus.new_tag_o[0] !== TAG_W'(5) || bus.new_tag_o[1] !== TAG_W'(7)) begin
            errors++; $display("FAIL bypass_next: got count=%0d we=%b {%0d,%0d} want 2 11 {7,5}",
                bus.free_count_o, bus.new_tag_write_en_o, bus.new_tag_o[1], bus.new_tag_o[0]);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(0)) begin
            errors++; $display("FAIL bypass_count: got %0d want 0", bus.free_count_o);
        end
        tick();
    endtask

    // Only slot1 requests: it takes rank 0 (head), slot0 is not granted.
    task automatic test_partial();
        do_reset();
        bus.alloc_i = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.new_tag_write_en_o !== 2'b10 || bus.new_tag_o[1] !== TAG_W'(32)) begin
            errors++; $display("FAIL partial_slot1: got we=%b tag1=%0d want 10/32", bus.new_tag_write_en_o, bus.new_tag_o[1]);
        end
        tick();
        bus.alloc_i = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(31) || bus.new_tag_write_en_o !== 2'b11
            || bus.new_tag_o[0] !== TAG_W'(33) || bus.new_tag_o[1] !== TAG_W'(34)) begin
            errors++; $display("FAIL partial_next: got count=%0d we=%b {%0d,%0d} want 31 11 {34,33}",
                bus.free_count_o, bus.new_tag_write_en_o, bus.new_tag_o[1], bus.new_tag_o[0]);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(29)) begin
            errors++; $display("FAIL partial_count: got %0d want 29", bus.free_count_o);
        end
        tick();
    endtask

    // 6 allocs, then frees {40,41} with recover: head snaps to tail = 2,
    // and ring slot 2 still holds its reset value 34.
    task automatic test_recover();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.alloc_i = 2'b11;
            @(negedge clk);
            checks++;
            if (bus.new_tag_o[0] !== TAG_W'(32 + 2*c) || bus.new_tag_o[1] !== TAG_W'(33 + 2*c)) begin
                errors++; $display("FAIL recover_alloc_c%0d: got {%0d,%0d} want {%0d,%0d}", c,
                    bus.new_tag_o[1], bus.new_tag_o[0], 33 + 2*c, 32 + 2*c);
            end
            tick();
        end
        bus.alloc_i          = 2'b11;
        bus.free_en_i        = 2'b11;
        bus.free_tag_i[0]    = TAG_W'(40);
        bus.free_tag_i[1]    = TAG_W'(41);
        bus.branch_recover_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.new_tag_write_en_o !== 2'b00) begin
            errors++; $display("FAIL recover_grant: got we=%b want 00", bus.new_tag_write_en_o);
        end
        tick();
        drive_idle();
        bus.alloc_i = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(32) || bus.stall_o !== 1'b0) begin
            errors++; $display("FAIL recover_count: got count=%0d stall=%b want 32/0", bus.free_count_o, bus.stall_o);
        end
        checks++;
        if (bus.new_tag_write_en_o !== 2'b01 || bus.new_tag_o[0] !== TAG_W'(34)) begin
            errors++; $display("FAIL recover_head: got we=%b tag0=%0d want 01/34", bus.new_tag_write_en_o, bus.new_tag_o[0]);
        end
        tick();
        drive_idle();
    endtask

    // Reset mid-stream beats pending allocs and restores the reset image.
    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.alloc_i = 2'b11;
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.new_tag_write_en_o !== 2'b00) begin
            errors++; $display("FAIL midreset_grant: got we=%b want 00", bus.new_tag_write_en_o);
        end
        tick();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus.free_count_o !== CNT_W'(32) || bus.new_tag_o[0] !== TAG_W'(32) || bus.new_tag_o[1] !== TAG_W'(33)) begin
            errors++; $display("FAIL midreset_state: got count=%0d {%0d,%0d} want 32 {33,32}",
                bus.free_count_o, bus.new_tag_o[1], bus.new_tag_o[0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_no_bypass();
        test_partial();
        test_recover();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_free_list
`default_nettype wire
